// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: FSM states, result-select encoding, default tag width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_QUO = 1'b0,
    OP_REM = 1'b1
  } op_t;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves to whichever port is granted.
// Latency: grant is combinational from i_req/i_en; pointer updates on the clock edge that accepts.
// Backpressure: no grant while i_en is low; a grant is an accept (requests already qualified by caller).
//
// Ports:
//   clk, resetn : clock, async active-low reset (pointer resets to 1 so port 0 wins first)
//   i_req[1:0]  : qualified requests
//   i_en        : arbiter may grant this cycle
//   o_gnt[1:0]  : one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic       r_last;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        // Contention: favour the port that did not win last time.
        w_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters; returns quotient or remainder to the owner.
// Latency: accept at T -> div_o from T+1 -> div_complete_i at T+34 -> resp_valid from T+35.
// Backpressure: one op in flight; req_ready only in IDLE; RESP holds until resp_ready or owner flush.
//
// Ports:
//   req_*[1:0]     : per-requester valid/ready, signed, op (0 quo / 1 rem), x, y, tag
//   flush[1:0]     : cancel the requester's outstanding op (no effect on the other port's op)
//   resp_*         : per-port valid/ready, shared data and tag
//   div_*          : divider run strobe, signed select, operands; quotient/remainder/complete back
module div_arbiter
  import div_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_signed,
  input  logic [1:0]            req_op,
  input  logic [1:0][31:0]      req_x,
  input  logic [1:0][31:0]      req_y,
  input  logic [1:0][TAG_W-1:0] req_tag,
  input  logic [1:0]            flush,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [31:0]           resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  div_o,
  output logic                  div_signed_o,
  output logic [31:0]           div_x_o,
  output logic [31:0]           div_y_o,
  input  logic [31:0]           div_s_i,
  input  logic [31:0]           div_r_i,
  input  logic                  div_complete_i
);

  state_t           r_state;
  logic             r_owner;
  op_t              r_op;
  logic             r_signed;
  logic [31:0]      r_x;
  logic [31:0]      r_y;
  logic [TAG_W-1:0] r_tag;
  logic             r_div;
  logic [1:0]       r_resp_vld;
  logic [31:0]      r_resp_data;

  logic [1:0] w_gnt;
  logic       w_accept;
  logic       w_sel;
  logic       w_own_flush;
  logic       w_arb_en;

  // A port flushing this cycle is never offered ready, so it is removed from arbitration.
  // resetn gates the enable so req_ready reads 0 while reset is held.
  assign w_arb_en    = (r_state == ST_IDLE) && resetn;
  assign w_accept    = |w_gnt;
  assign w_sel       = w_gnt[1];
  assign w_own_flush = flush[r_owner];

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .resetn (resetn),
    .i_req  (req_valid & ~flush),
    .i_en   (w_arb_en),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_op        <= OP_QUO;
      r_signed    <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_tag       <= '0;
      r_div       <= 1'b0;
      r_resp_vld  <= 2'b00;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner  <= w_sel;
            r_signed <= req_signed[w_sel];
            r_op     <= op_t'(req_op[w_sel]);
            r_x      <= req_x[w_sel];
            r_y      <= req_y[w_sel];
            r_tag    <= req_tag[w_sel];
            r_div    <= 1'b1;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_own_flush) begin
            // Flush wins over a simultaneous completion. Otherwise keep the divider
            // running so its counter wraps back to zero before it is reused.
            if (div_complete_i) begin
              r_div   <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (div_complete_i) begin
            r_resp_data <= (r_op == OP_REM) ? div_r_i : div_s_i;
            r_resp_vld  <= r_owner ? 2'b10 : 2'b01;
            r_div       <= 1'b0;
            r_state     <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (div_complete_i) begin
            r_div   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (w_own_flush || resp_ready[r_owner]) begin
            r_resp_vld <= 2'b00;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_div      <= 1'b0;
          r_resp_vld <= 2'b00;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_gnt;
  assign resp_valid   = r_resp_vld;
  assign resp_data    = r_resp_data;
  assign resp_tag     = r_tag;
  assign div_o        = r_div;
  assign div_signed_o = r_signed;
  assign div_x_o      = r_x;
  assign div_y_o      = r_y;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with a 34-cycle iterative divider model.
// Latency: checks accept -> resp_valid distance of 35 cycles.
// Backpressure: exercises resp_ready stalls, flushes and mid-op reset.
module tb_div_arbiter;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [1:0]       req_valid, req_ready, req_signed, req_op, flush;
  logic [1:0]       resp_valid, resp_ready;
  logic [1:0][31:0] req_x, req_y;
  logic [1:0][3:0]  req_tag;
  logic [31:0]      resp_data;
  logic [3:0]       resp_tag;
  logic             div_o, div_signed_o, div_complete_i;
  logic [31:0]      div_x_o, div_y_o, div_s_i, div_r_i;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .div_o(div_o), .div_signed_o(div_signed_o), .div_x_o(div_x_o), .div_y_o(div_y_o),
    .div_s_i(div_s_i), .div_r_i(div_r_i), .div_complete_i(div_complete_i)
  );

  // Divider model: completes on the 34th consecutive cycle of div_o, counter back to 0 after.
  logic [5:0] dcnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) dcnt <= '0;
    else if (div_o) dcnt <= (dcnt == 6'd33) ? 6'd0 : dcnt + 6'd1;
    else dcnt <= '0;
  end
  assign div_complete_i = div_o && (dcnt == 6'd33);

  always_comb begin
    div_s_i = 32'hFFFF_FFFF;
    div_r_i = div_x_o;
    if (div_y_o != 32'd0) begin
      if (div_signed_o) begin
        div_s_i = $signed(div_x_o) / $signed(div_y_o);
        div_r_i = $signed(div_x_o) % $signed(div_y_o);
      end else begin
        div_s_i = div_x_o / div_y_o;
        div_r_i = div_x_o % div_y_o;
      end
    end
  end

  typedef struct {
    logic        p;
    logic [31:0] data;
    logic [3:0]  tag;
    int          t_acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        p;
    logic        sgn;
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: expected event did not occur within bound (cycle %0d)", name, cyc);
  endtask

  task automatic drive_req(input logic p, input logic sgn, input logic op,
                           input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag);
    req_signed[p] = sgn;
    req_op[p]     = op;
    req_x[p]      = x;
    req_y[p]      = y;
    req_tag[p]    = tag;
    req_valid[p]  = 1'b1;
  endtask

  // Called at a negedge; returns the cycle in which the handshake is visible.
  task automatic wait_accept(input logic p, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_valid[p] && req_ready[p]) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) timeout("accept_wait");
  endtask

  task automatic wait_resp(input logic p, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (resp_valid[p]) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) timeout("resp_wait");
  endtask

  task automatic accept_op(input logic p, input logic sgn, input logic op,
                           input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag,
                           input logic [31:0] exp, output int t);
    exp_t e;
    drive_req(p, sgn, op, x, y, tag);
    wait_accept(p, t);
    if (t >= 0) begin
      chk("div_o_at_accept", div_o, 1'b0);
      e.p = p; e.data = exp; e.tag = tag; e.t_acc = t;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[p] = 1'b0;
    if (t >= 0) begin
      #1;
      chk("div_o_run", div_o, 1'b1);
      chk("div_x_o", div_x_o, x);
      chk("div_y_o", div_y_o, y);
      chk("div_signed_o", div_signed_o, sgn);
    end
  endtask

  task automatic end_op(output int tr);
    exp_t e;
    logic p;
    tr = -1;
    if (sb.size() == 0) begin
      timeout("scoreboard_empty");
      return;
    end
    p = sb[0].p;
    wait_resp(p, tr);
    e = sb.pop_front();
    if (tr >= 0) begin
      chk("latency", tr - e.t_acc, 35);
      chk("resp_data", resp_data, e.data);
      chk("resp_tag", resp_tag, e.tag);
      chk("resp_valid_port", resp_valid, e.p ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    #1;
    chk("resp_valid_drop", resp_valid, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tr, bd, bv, br, bs;
    logic [31:0] d0;
    logic [3:0]  g0;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'd100,        32'd7,          4'd3,  32'd14};
    vt[1] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          4'hA,  32'hFFFF_FFFD};
    vt[2] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          4'hB,  32'hFFFF_FFFF};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          4'h1,  32'h7FFF_FFFC};
    vt[4] = '{1'b0, 1'b0, 1'b1, 32'd100,        32'd7,          4'h2,  32'd2};
    vt[5] = '{1'b1, 1'b0, 1'b0, 32'd5,          32'd0,          4'hC,  32'hFFFF_FFFF};
    vt[6] = '{1'b1, 1'b0, 1'b1, 32'd5,          32'd0,          4'hD,  32'd5};
    vt[7] = '{1'b0, 1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  4'hE,  32'd1};
    vt[8] = '{1'b1, 1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  4'hF,  32'hFFFF_FFFD};

    req_valid = '0; req_signed = '0; req_op = '0; req_x = '0; req_y = '0; req_tag = '0;
    flush = '0; resp_ready = 2'b11;

    // Reset values with both ports already requesting 10/3.
    drive_req(1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 4'd1);
    drive_req(1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 4'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", resp_tag, 4'd0);
    chk("rst_div_o", div_o, 1'b0);
    chk("rst_div_x", div_x_o, 32'd0);
    chk("rst_div_y", div_y_o, 32'd0);
    chk("rst_div_signed", div_signed_o, 1'b0);

    // Round-robin out of reset: port 0 first, port 1 the cycle after port 0's handshake.
    resetn = 1'b1;
    #1;
    chk("rr_first_grant", req_ready, 2'b01);
    accept_op(1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 4'd1, 32'd3, ta);
    chk("busy_ready_low", req_ready, 2'b00);
    end_op(tr);
    accept_op(1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 4'd2, 32'd3, tb);
    chk("rr_second_gap", tb - tr, 1);
    end_op(tr);

    // Table of single-port operations.
    for (int i = 0; i < 9; i++) begin
      accept_op(vt[i].p, vt[i].sgn, vt[i].op, vt[i].x, vt[i].y, vt[i].tag, vt[i].exp, ta);
      end_op(tr);
    end

    // Owner flush mid-op: divider keeps running to completion, no response.
    drive_req(1'b0, 1'b0, 1'b0, 32'd50, 32'd5, 4'd5);
    wait_accept(1'b0, ta);
    @(negedge clk);
    req_valid[0] = 1'b0;
    while (cyc < ta + 10) @(negedge clk);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 32'd81, 32'd9, 4'd6);
    bd = 0; bv = 0; br = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (div_o !== 1'b1) bd++;
      if (resp_valid !== 2'b00) bv++;
      if (req_ready !== 2'b00) br++;
      @(negedge clk);
    end
    chk("drain_div_o_low_cycles", bd, 0);
    chk("drain_resp_valid_cycles", bv, 0);
    chk("drain_req_ready_cycles", br, 0);
    accept_op(1'b0, 1'b0, 1'b0, 32'd81, 32'd9, 4'd6, 32'd9, tb);
    chk("drain_ready_at_35", tb - ta, 35);
    end_op(tr);

    // Flush coinciding with completion: result discarded, IDLE next cycle.
    drive_req(1'b1, 1'b0, 1'b0, 32'd20, 32'd4, 4'd8);
    wait_accept(1'b1, ta);
    @(negedge clk);
    req_valid[1] = 1'b0;
    while (cyc < ta + 34) @(negedge clk);
    #1;
    chk("complete_at_34", div_complete_i, 1'b1);
    flush[1] = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'd40, 32'd8, 4'd2);
    @(negedge clk);
    flush[1] = 1'b0;
    #1;
    chk("flush_cmpl_resp_valid", resp_valid, 2'b00);
    chk("flush_cmpl_ready", req_ready, 2'b01);
    accept_op(1'b0, 1'b0, 1'b0, 32'd40, 32'd8, 4'd2, 32'd5, tb);
    end_op(tr);

    // Owner flush while in RESP: resp_valid drops next cycle.
    resp_ready[0] = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 32'd60, 32'd7, 4'd3);
    wait_accept(1'b0, ta);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive_req(1'b1, 1'b0, 1'b1, 32'd60, 32'd7, 4'd4);
    wait_resp(1'b0, tr);
    chk("flush_resp_data", resp_data, 32'd8);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    chk("flush_resp_drop", resp_valid, 2'b00);
    chk("flush_resp_ready", req_ready, 2'b10);
    resp_ready[0] = 1'b1;
    accept_op(1'b1, 1'b0, 1'b1, 32'd60, 32'd7, 4'd4, 32'd4, tb);
    end_op(tr);

    // resp_ready stall for 5 cycles; non-owner flush during BUSY is ignored.
    resp_ready[0] = 1'b0;
    accept_op(1'b0, 1'b0, 1'b1, 32'd30, 32'd4, 4'd9, 32'd2, ta);
    drive_req(1'b1, 1'b0, 1'b0, 32'd30, 32'd4, 4'd5);
    while (cyc < ta + 5) @(negedge clk);
    flush[1] = 1'b1;
    @(negedge clk);
    flush[1] = 1'b0;
    wait_resp(1'b0, tr);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall_latency", tr - e.t_acc, 35);
      chk("stall_resp_data", resp_data, e.data);
      chk("stall_resp_tag", resp_tag, e.tag);
    end
    d0 = resp_data;
    g0 = resp_tag;
    bs = 0; br = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (resp_data !== d0 || resp_tag !== g0 || resp_valid !== 2'b01) bs++;
      if (req_ready !== 2'b00) br++;
    end
    chk("stall_unstable_cycles", bs, 0);
    chk("stall_ready_cycles", br, 0);
    resp_ready[0] = 1'b1;
    accept_op(1'b1, 1'b0, 1'b0, 32'd30, 32'd4, 4'd5, 32'd7, tb);
    chk("stall_next_accept", tb - tr, 6);
    end_op(tr);

    // Reset mid-operation, then a fresh 9/4 completes normally.
    accept_op(1'b0, 1'b0, 1'b0, 32'd1000, 32'd10, 4'd4, 32'd100, ta);
    while (cyc < ta + 20) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_div_o", div_o, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 2'b00);
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_div_x", div_x_o, 32'd0);
    chk("mid_rst_resp_tag", resp_tag, 4'd0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    accept_op(1'b0, 1'b0, 1'b0, 32'd9, 32'd4, 4'd7, 32'd2, ta);
    end_op(tr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, response-routing tag width.
REQ-002 SHALL have port clk  input  1  sole clock.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset; the same net also drives the shared divider.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid, index 0/1.
REQ-005 SHALL have port req_ready  output  2  per-requester accept.
REQ-006 SHALL have port req_signed  input  2  signed divide select.
REQ-007 SHALL have port req_op  input  2  result select per requester: 0 = quotient, 1 = remainder.
REQ-008 SHALL have port req_x  input  2x32  dividend per requester.
REQ-009 SHALL have port req_y  input  2x32  divisor per requester.
REQ-010 SHALL have port req_tag  input  2xTAG_W  requester tag.
REQ-011 SHALL have port flush  input  2  cancel the requester's outstanding operation.
REQ-012 SHALL have port resp_valid  output  2  per-requester result valid.
REQ-013 SHALL have port resp_ready  input  2  per-requester result accept.
REQ-014 SHALL have port resp_data  output  32  selected quotient/remainder, shared by both ports.
REQ-015 SHALL have port resp_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port div_o  output  1  divider run strobe.
REQ-017 SHALL have port div_signed_o  output  1  divider signed select.
REQ-018 SHALL have port div_x_o, div_y_o  output  32 each  divider operands.
REQ-019 SHALL have port div_s_i, div_r_i  input  32 each  divider quotient, remainder.
REQ-020 SHALL have port div_complete_i  input  1  divider done.

Function
REQ-021 SHALL implement FSM IDLE, BUSY, DRAIN, RESP.
REQ-022 SHALL assert req_ready only in IDLE: only for the granted port, never for a port whose flush is high that cycle.
REQ-023 SHALL grant round-robin: if only one port is valid, grant it; if both are valid, grant the port not granted last; the last-grant pointer resets to 1, so port 0 wins first.
REQ-024 SHALL register signed, op, x, y and tag on accept, then go IDLE->BUSY; div_x_o, div_y_o and div_signed_o come from these registers and are held stable until the next accept.
REQ-025 SHALL drive div_o = 1 in BUSY and DRAIN, including the cycle div_complete_i is high, so the divider counter returns to 0; div_o = 0 in IDLE and RESP.
REQ-026 Latency: accept at cycle T -> div_o high from T+1 -> div_complete_i high at T+34 -> resp_valid high from T+35.
REQ-027 BUSY with div_complete_i: SHALL capture div_s_i or div_r_i per op into resp_data, then go to RESP.
REQ-028 RESP SHALL hold resp_valid, resp_data and resp_tag stable until resp_ready; on the handshake, go to IDLE with no new accept in that cycle.
REQ-029 flush of the owning port in BUSY SHALL go to DRAIN; DRAIN keeps div_o = 1 until div_complete_i, then goes to IDLE and discards the result. The divider is never abandoned mid-count.
REQ-030 flush of the owning port in RESP SHALL drop resp_valid next cycle and go to IDLE.
REQ-031 flush of the non-owning port SHALL have no effect on the current operation.
REQ-032 flush and div_complete_i in the same BUSY cycle SHALL resolve as flush: the result is discarded and the FSM goes to IDLE.
REQ-033 Divide-by-zero SHALL pass the divider output through unmodified, with no special case.

Reset
REQ-034 On resetn low, asynchronously: state = IDLE; req_ready = 0; resp_valid = 0; resp_data = 0; resp_tag = 0; div_o = 0; operand registers = 0; last-grant = 1.
REQ-035 Reset mid-operation SHALL abort with no response; the divider is reset by the same net.

Structure
REQ-036 SHALL take the FSM state enum, the op encoding and the default TAG_W from shared package div_pkg.
REQ-037 SHALL use a single sub-module, rr_arb2: 2-way round-robin grant with a pointer update on accept.

Verification
REQ-038 Port 0 unsigned 100/7, op = 0, tag = 3, accepted at T -> resp_valid[0] at T+35, resp_data = 14, resp_tag = 3.
REQ-039 Port 1 signed -7/2 -> op 0 gives 0xFFFFFFFD; op 1 gives 0xFFFFFFFF.
REQ-040 Both ports valid from reset with 10/3 each -> port 0 granted first; port 1 accepted the cycle after port 0's resp handshake.
REQ-041 flush[0] at T+10 of a port-0 op -> no resp_valid; div_o high through T+34; req_ready next seen at T+35.
REQ-042 resp_ready low for 5 cycles in RESP -> resp_data and resp_tag stable; req_ready stays 0 throughout.
REQ-043 resetn low at T+20 mid-op -> all outputs at reset values immediately; a fresh 9/4 request then completes with quotient 2 at its T+35.
